// File: rtl/unibus_arb.sv
// Central Unibus arbiter: picks one of NPR / BR7..BR4 against the CPU priority
// and drives a single grant line, dropping it on SACK, withdrawal or timeout.
module unibus_arb #(
  parameter int TIMEOUT = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_init,
  input  logic [7:4] bus_br,
  input  logic       bus_npr,
  input  logic       bus_sack,
  input  logic [2:0] cpu_prio,
  input  logic       cpu_br_enb,
  output logic [7:4] bus_bg,
  output logic       bus_npg,
  output logic       nosack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, SACKED} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    sel_q;     // one-hot {NPG, BG7, BG6, BG5, BG4}
  logic [4:0]    grant_q;
  logic          nosack_q;
  logic [4:0]    sel_d;
  logic          req_held;

  // NPR ignores masking; BRn must beat the processor priority.
  always_comb begin
    sel_d = '0;
    if (bus_npr)                                    sel_d = 5'b10000;
    else if (cpu_br_enb) begin
      if      (bus_br[7] && (cpu_prio < 3'd7))      sel_d = 5'b01000;
      else if (bus_br[6] && (cpu_prio < 3'd6))      sel_d = 5'b00100;
      else if (bus_br[5] && (cpu_prio < 3'd5))      sel_d = 5'b00010;
      else if (bus_br[4] && (cpu_prio < 3'd4))      sel_d = 5'b00001;
    end
  end

  assign req_held = |(sel_q & {bus_npr, bus_br});

  always_ff @(posedge clk) begin
    if (reset || bus_init) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      nosack_q <= 1'b0;
    end else begin
      nosack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|sel_d) begin
            sel_q   <= sel_d;
            grant_q <= sel_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (bus_sack) begin
            grant_q <= '0;
            state_q <= SACKED;
          end else if (!req_held) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            grant_q  <= '0;
            nosack_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SACKED: begin
          // BBSY is not watched: the next master waits for it itself.
          if (!bus_sack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_bg  = grant_q[3:0];
  assign bus_npg = grant_q[4];
  assign nosack  = nosack_q;

endmodule

// File: tb/tb_unibus_arb.sv
// Directed vector table plus hand sequences for timeout / SACK-vs-timeout races.
module tb_unibus_arb;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset, bus_init, bus_npr, bus_sack, cpu_br_enb;
  logic [7:4] bus_br, bus_bg;
  logic [2:0] cpu_prio;
  logic       bus_npg, nosack;
  logic       mon_en = 1'b0;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  unibus_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus_init(bus_init), .bus_br(bus_br),
    .bus_npr(bus_npr), .bus_sack(bus_sack), .cpu_prio(cpu_prio),
    .cpu_br_enb(cpu_br_enb), .bus_bg(bus_bg), .bus_npg(bus_npg), .nosack(nosack)
  );

  typedef struct packed {
    logic       init;
    logic [3:0] br;
    logic       npr;
    logic       sack;
    logic [2:0] prio;
    logic       enb;
    logic [3:0] bg;
    logic       npg;
    logic       ns;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic init, input logic [3:0] br, input logic npr,
                              input logic sack, input logic [2:0] prio, input logic enb,
                              input logic [3:0] bg, input logic npg, input logic ns);
    vec_t v;
    v.init = init; v.br = br; v.npr = npr; v.sack = sack; v.prio = prio; v.enb = enb;
    v.bg = bg; v.npg = npg; v.ns = ns;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic init, input logic [3:0] br, input logic npr,
                       input logic sack, input logic [2:0] prio, input logic enb);
    bus_init = init; bus_br = br; bus_npr = npr; bus_sack = sack;
    cpu_prio = prio; cpu_br_enb = enb;
  endtask

  task automatic step_chk(input string nm, input logic [3:0] bg, input logic npg, input logic ns);
    @(posedge clk); #1;
    chk({nm, ".bg"}, {4'b0, bus_bg}, {4'b0, bg});
    chk({nm, ".npg"}, {7'b0, bus_npg}, {7'b0, npg});
    chk({nm, ".nosack"}, {7'b0, nosack}, {7'b0, ns});
  endtask

  // Grant lines must be one-hot or all zero every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (!$onehot0({bus_bg, bus_npg})) begin
        bad++;
        $display("FAIL onehot: got bg=%b npg=%b want at most one high", bus_bg, bus_npg);
      end
    end
  end

  initial begin
    //              init br     npr sack prio enb  bg     npg ns
    // line clock BR6, SACK, release
    tbl.push_back(mk(0, 4'b0100, 0, 0, 3'd0, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 3'd0, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 3'd0, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    // masking
    tbl.push_back(mk(0, 4'b0110, 0, 0, 3'd6, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, 0, 0, 3'd6, 1, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 4'b1110, 0, 1, 3'd6, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 3'd0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 3'd0, 0, 4'b0000, 0, 0));
    // NPR beats BR7, then BR7 after release
    tbl.push_back(mk(0, 4'b1000, 1, 0, 3'd0, 1, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 0, 3'd0, 1, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    // BR6+BR5 at prio 4 -> BG6, then withdraw
    tbl.push_back(mk(0, 4'b0110, 0, 0, 3'd4, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd4, 1, 4'b0000, 0, 0));
    // BR5 withdrawal: no nosack
    tbl.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    // INIT mid-grant, then INIT together with a request
    tbl.push_back(mk(0, 4'b0100, 0, 0, 3'd0, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 0, 3'd0, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    // SACK together with withdrawal -> SACKED holds off regrant
    tbl.push_back(mk(0, 4'b0001, 0, 0, 3'd0, 1, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 3'd0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 1, 4'b0000, 0, 0));
    // priority/enable change after grant does not revoke it
    tbl.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 3'd7, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 3'd7, 0, 4'b0000, 0, 0));

    reset = 1'b1;
    drive(0, 4'b0000, 0, 0, 3'd0, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    step_chk("reset", 4'b0000, 0, 0);
    // request held during reset must not be granted
    drive(0, 4'b1000, 1, 0, 3'd0, 1);
    step_chk("reset_req", 4'b0000, 0, 0);
    reset = 1'b0;
    drive(0, 4'b0000, 0, 0, 3'd0, 1);
    step_chk("idle", 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].init, tbl[i].br, tbl[i].npr, tbl[i].sack, tbl[i].prio, tbl[i].enb);
      step_chk($sformatf("vec%0d", i), tbl[i].bg, tbl[i].npg, tbl[i].ns);
    end

    // Timeout: BG4 high exactly TO cycles, one nosack pulse, regrant next cycle.
    drive(0, 4'b0001, 0, 0, 3'd0, 1);
    for (int c = 0; c < TO; c++) step_chk($sformatf("to_hi%0d", c), 4'b0001, 0, 0);
    step_chk("to_drop", 4'b0000, 0, 1);
    step_chk("to_regrant", 4'b0001, 0, 0);
    // SACK on the timeout edge wins: no pulse.
    for (int c = 1; c < TO; c++) step_chk($sformatf("to2_hi%0d", c), 4'b0001, 0, 0);
    drive(0, 4'b0001, 0, 1, 3'd0, 1);
    step_chk("sack_vs_to", 4'b0000, 0, 0);
    drive(0, 4'b0000, 0, 0, 3'd0, 1);
    step_chk("sack_vs_to_rel", 4'b0000, 0, 0);
    step_chk("final_idle", 4'b0000, 0, 0);

    // NPR timeout path and withdrawal of NPR
    drive(0, 4'b0000, 1, 0, 3'd7, 0);
    step_chk("npr_masked_ok", 4'b0000, 1, 0);
    drive(0, 4'b0000, 0, 0, 3'd7, 0);
    step_chk("npr_withdraw", 4'b0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
